execute_stage_mc: RTL and testbench
===================================

Name: execute_stage_mc

Overview:
Parametrised next-generation execute stage. Contains the operand-select muxes and an N-source forwarding mux. It also contains a single-cycle ALU, an iterative W-cycle multiply/divide unit with a stall handshake, and a flags register with a write-back restore path. It sits between the ID/EX and EX/MEM pipeline registers and drives the pipeline stall network.

Parameters:
W, 16, datapath width in bits (at least 4).
NFWD, 3, number of forwarding sources.
SW, $clog2(W), shift-amount width.
FSW, $clog2(NFWD+1), forwarding-select width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
valid_in  in  1  instruction present in EX.
op  in  4  operation code (see Behaviour).
a_sel  in  2  source for A: 00 rsrc, 01 in_port, 10 imm, 11 sp_low.
b_sel  in  1  source for B: 0 rdst, 1 shamt zero-extended to W.
fwd_a_sel  in  FSW  0 = a_sel mux output; k = fwd_data slice k-1.
fwd_b_sel  in  FSW  same as fwd_a_sel, applied to B.
rsrc, rdst, imm, sp_low, in_port  in  W each  operand sources.
shamt  in  SW  shift amount.
fwd_data  in  NFWD*W  forwarded values; slice k occupies bits [k*W+W-1 : k*W].
flags_we  in  1  update flags on completion.
flags_restore  in  1  load flags_restore_val (RTI path).
flags_restore_val  in  3  {C,N,Z} value to restore.
flush  in  1  kill the in-flight operation.
stall_out  out  1  EX busy; upstream must hold its instruction.
valid_out  out  1  result and result_hi are valid this cycle.
result  out  W  registered result (low half for MUL, quotient for DIV).
result_hi  out  W  registered MUL high half / DIV remainder; 0 for other ops.
flags_out  out  3  registered {C,N,Z}.
operand_a  out  W  combinational final A after forwarding (SP-before value).

Behaviour:
- Reset (async): state IDLE, counter 0, valid_out 0, result 0, result_hi 0, flags_out 000.
- Forwarding: a fwd select above NFWD selects the mux output.
- Op codes:
  - 0 MOV: A.
  - 1 ADD: B+A.
  - 2 SUB: B-A.
  - 3 AND, 4 OR.
  - 5 NOT: ~B.
  - 6 INC: B+1.
  - 7 DEC: B-1.
  - 8 SHL: B<<shamt.
  - 9 SHR: B>>shamt (logical).
  - A SETC, B CLRC.
  - C MUL: unsigned A*B.
  - D DIVU: B/A.
  - E, F: pass B.
- Single-cycle ops: if valid_in is high in IDLE at edge e0, result is registered at e0. valid_out=1 for one cycle after e0. Latency is 1.
- Multi-cycle ops (MUL, DIVU): accepted at edge e0. Operands and flags_we are captured, state becomes BUSY, counter is set to W-1.
  - One shift-add (MUL) or restoring-subtract (DIVU) iteration is performed per edge.
  - At the edge where the counter is 0 (eW), result and result_hi are written, valid_out pulses for one cycle, and state returns to IDLE.
  - stall_out = (state==BUSY), combinational. It is high for exactly W cycles. valid_in is ignored while BUSY.
- Flag rules, applied at the result-write edge only when flags_we is high:
  - Z = (result==0); N = result[W-1].
  - C for ADD/INC: carry out. C for SUB/DEC: borrow.
  - C for SHL/SHR: last bit shifted out; shamt==0 leaves C unchanged.
  - C for MUL: result_hi!=0. C for DIVU: divide-by-zero.
  - SETC/CLRC set C to 1/0 and leave N and Z unchanged.
  - MOV, AND, OR, NOT: C unchanged.
- Divide by zero: quotient all-ones; remainder = dividend (B).
- flags_restore has priority over any flag update in the same cycle and is applied whenever it is high, even while BUSY.
- flush: on that edge state goes to IDLE, no valid_out is produced, and flags are unchanged. A valid_in in the same cycle as flush is dropped. flush while IDLE only clears valid_out.
- Reset asserted mid-operation returns everything to reset values immediately.

Test Plan:
- W=16, ADD, A=0x0001, B=0xFFFF, flags_we=1 -> next cycle result=0x0000, valid_out=1, flags_out={C1,N0,Z1}.
- MUL, A=0x0100, B=0x0300 -> stall_out high for 16 cycles; then result=0x0000, result_hi=0x0003, valid_out pulse, C=1.
- DIVU, B=100, A=0 -> after 16 cycles result=0xFFFF, result_hi=100, C=1.
- fwd_a_sel=2 with fwd_data slice1=0x1234, MOV -> operand_a=0x1234 combinationally; result=0x1234 next cycle.
- flush asserted at cycle 5 of a MUL -> state IDLE, stall_out drops, no valid_out, flags unchanged; the next ADD completes in 1 cycle.
- flags_restore=1 with value 3'b101 in the same cycle as a flag-writing SUB -> flags_out=101. Async rst mid-DIVU -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/execute_stage_mc.sv
// Execute stage: operand muxes, forwarding, single-cycle ALU, iterative
// MUL/DIVU unit with stall, and {C,N,Z} flags register with restore path.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   valid_in, op          instruction present / operation code
//   a_sel, b_sel          operand source selects
//   fwd_a_sel, fwd_b_sel  forwarding selects (0 = mux, k = fwd slice k-1)
//   rsrc, rdst, imm,
//   sp_low, in_port       operand sources
//   shamt                 shift amount
//   fwd_data              NFWD forwarded values, W bits each
//   flags_we              update flags on completion
//   flags_restore(_val)   RTI flags reload, highest priority
//   flush                 kill in-flight operation
//   stall_out             EX busy with a multi-cycle op
//   valid_out             result/result_hi valid this cycle
//   result, result_hi     registered results
//   flags_out             registered {C,N,Z}
//   operand_a             final A after forwarding (combinational)

module execute_stage_mc #(
  parameter int W    = 16,
  parameter int NFWD = 3,
  parameter int SW   = $clog2(W),
  parameter int FSW  = $clog2(NFWD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [3:0]      op,
  input  logic [1:0]      a_sel,
  input  logic            b_sel,
  input  logic [FSW-1:0]  fwd_a_sel,
  input  logic [FSW-1:0]  fwd_b_sel,
  input  logic [W-1:0]    rsrc,
  input  logic [W-1:0]    rdst,
  input  logic [W-1:0]    imm,
  input  logic [W-1:0]    sp_low,
  input  logic [W-1:0]    in_port,
  input  logic [SW-1:0]   shamt,
  input  logic [NFWD*W-1:0] fwd_data,
  input  logic            flags_we,
  input  logic            flags_restore,
  input  logic [2:0]      flags_restore_val,
  input  logic            flush,
  output logic            stall_out,
  output logic            valid_out,
  output logic [W-1:0]    result,
  output logic [W-1:0]    result_hi,
  output logic [2:0]      flags_out,
  output logic [W-1:0]    operand_a
);

  localparam int CW = $clog2(W);

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_DEC  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_SETC = 4'hA;
  localparam logic [3:0] OP_CLRC = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIVU = 4'hD;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // multi-cycle datapath: x = multiplicand/divisor,
  // hi = partial product/remainder, lo = multiplier/quotient
  logic [W-1:0]  x_reg;
  logic [W-1:0]  hi_reg;
  logic [W-1:0]  lo_reg;
  logic          is_div;
  logic          mc_fwe;

  logic [W-1:0]  a_mux;
  logic [W-1:0]  b_mux;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;

  // ---------------- operand select ----------------
  always_comb begin
    case (a_sel)
      2'b00:   a_mux = rsrc;
      2'b01:   a_mux = in_port;
      2'b10:   a_mux = imm;
      default: a_mux = sp_low;
    endcase
  end

  assign b_mux = b_sel ? W'(shamt) : rdst;

  // out-of-range selects fall through to the mux output
  always_comb begin
    op_a = a_mux;
    op_b = b_mux;
    for (int k = 1; k <= NFWD; k++) begin
      if (fwd_a_sel == FSW'(k))
        op_a = fwd_data[(k-1)*W +: W];
      if (fwd_b_sel == FSW'(k))
        op_b = fwd_data[(k-1)*W +: W];
    end
  end

  assign operand_a = op_a;
  assign stall_out = (state == BUSY);

  // ---------------- single-cycle ALU ----------------
  logic [W:0]   add_w;
  logic [W:0]   sub_w;
  logic [W:0]   inc_w;
  logic [W:0]   dec_w;
  logic [W:0]   shl_w;
  logic [W:0]   shr_w;
  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         keep_nz;
  logic [2:0]   alu_flags;
  logic         is_mc_op;

  assign add_w = {1'b0, op_b} + {1'b0, op_a};
  assign sub_w = {1'b0, op_b} - {1'b0, op_a};
  assign inc_w = {1'b0, op_b} + (W+1)'(1);
  assign dec_w = {1'b0, op_b} - (W+1)'(1);
  // extra bit catches the last bit shifted out
  assign shl_w = {1'b0, op_b} << shamt;
  assign shr_w = {op_b, 1'b0} >> shamt;

  assign is_mc_op = (op == OP_MUL) || (op == OP_DIVU);

  always_comb begin
    alu_res = op_b;
    alu_c   = flags_out[2];
    keep_nz = 1'b0;
    case (op)
      OP_MOV: alu_res = op_a;
      OP_ADD: {alu_c, alu_res} = add_w;
      OP_SUB: {alu_c, alu_res} = sub_w;
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_NOT: alu_res = ~op_b;
      OP_INC: {alu_c, alu_res} = inc_w;
      OP_DEC: {alu_c, alu_res} = dec_w;
      OP_SHL: begin
        alu_res = shl_w[W-1:0];
        if (shamt != '0)
          alu_c = shl_w[W];
      end
      OP_SHR: begin
        alu_res = shr_w[W:1];
        if (shamt != '0)
          alu_c = shr_w[0];
      end
      OP_SETC: begin
        alu_c   = 1'b1;
        keep_nz = 1'b1;
      end
      OP_CLRC: begin
        alu_c   = 1'b0;
        keep_nz = 1'b1;
      end
      default: alu_res = op_b;
    endcase
    if (keep_nz)
      alu_flags = {alu_c, flags_out[1:0]};
    else
      alu_flags = {alu_c, alu_res[W-1], alu_res == '0};
  end

  // ---------------- iterative MUL / DIVU step ----------------
  logic [W:0]   mul_sum;
  logic [W:0]   div_sh;
  logic [W:0]   div_diff;
  logic         div_ge;
  logic [W-1:0] step_hi;
  logic [W-1:0] step_lo;
  logic [2:0]   mc_flags;

  assign mul_sum  = {1'b0, hi_reg}
                  + (lo_reg[0] ? {1'b0, x_reg} : '0);
  assign div_sh   = {hi_reg, lo_reg[W-1]};
  assign div_ge   = div_sh >= {1'b0, x_reg};
  assign div_diff = div_sh - {1'b0, x_reg};

  // divisor 0 always "fits": quotient all ones,
  // remainder collects the dividend bits
  always_comb begin
    if (is_div) begin
      step_hi = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
      step_lo = {lo_reg[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo_reg[W-1:1]};
    end
  end

  assign mc_flags = {
    is_div ? (x_reg == '0) : (step_hi != '0),
    step_lo[W-1],
    step_lo == '0
  };

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      valid_out <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags_out <= '0;
      x_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      is_div    <= 1'b0;
      mc_fwe    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (valid_in) begin
              if (is_mc_op) begin
                state  <= BUSY;
                cnt    <= CW'(W-1);
                x_reg  <= op_a;
                hi_reg <= '0;
                lo_reg <= op_b;
                is_div <= (op == OP_DIVU);
                mc_fwe <= flags_we;
              end else begin
                result    <= alu_res;
                result_hi <= '0;
                valid_out <= 1'b1;
                if (flags_we)
                  flags_out <= alu_flags;
              end
            end
          end
          BUSY: begin
            hi_reg <= step_hi;
            lo_reg <= step_lo;
            if (cnt == '0) begin
              state     <= IDLE;
              result    <= step_lo;
              result_hi <= step_hi;
              valid_out <= 1'b1;
              if (mc_fwe)
                flags_out <= mc_flags;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (flags_restore)
        flags_out <= flags_restore_val;
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Scoreboard bench for execute_stage_mc: directed vectors push expected
// results; a negedge monitor pops and compares on every valid_out.

module tb_execute_stage_mc;

  localparam int W    = 16;
  localparam int NFWD = 3;
  localparam int SW   = 4;
  localparam int FSW  = 2;

  localparam logic [3:0] MOV  = 4'h0;
  localparam logic [3:0] ADD  = 4'h1;
  localparam logic [3:0] SUB  = 4'h2;
  localparam logic [3:0] AND_ = 4'h3;
  localparam logic [3:0] OR_  = 4'h4;
  localparam logic [3:0] NOT_ = 4'h5;
  localparam logic [3:0] INC  = 4'h6;
  localparam logic [3:0] DEC  = 4'h7;
  localparam logic [3:0] SHL  = 4'h8;
  localparam logic [3:0] SHR  = 4'h9;
  localparam logic [3:0] SETC = 4'hA;
  localparam logic [3:0] CLRC = 4'hB;
  localparam logic [3:0] MUL  = 4'hC;
  localparam logic [3:0] DIVU = 4'hD;
  localparam logic [3:0] PASS = 4'hE;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [3:0]        op;
  logic [1:0]        a_sel;
  logic              b_sel;
  logic [FSW-1:0]    fwd_a_sel;
  logic [FSW-1:0]    fwd_b_sel;
  logic [W-1:0]      rsrc;
  logic [W-1:0]      rdst;
  logic [W-1:0]      imm;
  logic [W-1:0]      sp_low;
  logic [W-1:0]      in_port;
  logic [SW-1:0]     shamt;
  logic [NFWD*W-1:0] fwd_data;
  logic              flags_we;
  logic              flags_restore;
  logic [2:0]        flags_restore_val;
  logic              flush;
  logic              stall_out;
  logic              valid_out;
  logic [W-1:0]      result;
  logic [W-1:0]      result_hi;
  logic [2:0]        flags_out;
  logic [W-1:0]      operand_a;

  execute_stage_mc #(
    .W(W), .NFWD(NFWD), .SW(SW), .FSW(FSW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .op(op),
    .a_sel(a_sel),
    .b_sel(b_sel),
    .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel),
    .rsrc(rsrc),
    .rdst(rdst),
    .imm(imm),
    .sp_low(sp_low),
    .in_port(in_port),
    .shamt(shamt),
    .fwd_data(fwd_data),
    .flags_we(flags_we),
    .flags_restore(flags_restore),
    .flags_restore_val(flags_restore_val),
    .flush(flush),
    .stall_out(stall_out),
    .valid_out(valid_out),
    .result(result),
    .result_hi(result_hi),
    .flags_out(flags_out),
    .operand_a(operand_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [2:0]   fl;
    bit           cr;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] r,
                      input logic [W-1:0] h,
                      input logic [2:0] f,
                      input bit cr);
    exp_t e;
    e.res = r;
    e.hi  = h;
    e.fl  = f;
    e.cr  = cr;
    sbq.push_back(e);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid_out) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid: result %0h", result);
        end else begin
          e = sbq.pop_front();
          if (e.cr)
            chk("res", 32'(result), 32'(e.res));
          chk("res_hi", 32'(result_hi), 32'(e.hi));
          chk("flags", 32'(flags_out), 32'(e.fl));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_ops(input logic [3:0] o,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [SW-1:0] sh,
                         input logic fwe);
    op        = o;
    a_sel     = 2'b00;
    b_sel     = 1'b0;
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    rsrc      = a;
    rdst      = b;
    shamt     = sh;
    flags_we  = fwe;
  endtask

  task automatic fire_sc(input logic [W-1:0] r,
                         input logic [2:0] f,
                         input bit cr);
    push(r, '0, f, cr);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    @(negedge clk);
    chk("sc_latency", 32'(valid_out), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic sc(input logic [3:0] o,
                    input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input logic [SW-1:0] sh,
                    input logic fwe,
                    input logic [W-1:0] r,
                    input logic [2:0] f);
    set_ops(o, a, b, sh, fwe);
    fire_sc(r, f, 1'b1);
  endtask

  task automatic run_mc(input logic [3:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic fwe,
                        input logic hold,
                        input logic [W-1:0] r,
                        input logic [W-1:0] h,
                        input logic [2:0] f);
    int n;
    set_ops(o, a, b, '0, fwe);
    push(r, h, f, 1'b1);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = hold;
    if (hold)
      op = ADD;
    n = 0;
    @(negedge clk);
    while (stall_out && n < 100) begin
      n++;
      @(negedge clk);
    end
    valid_in = 1'b0;
    chk("stall_cycles", 32'(n), 32'(W));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    flush = 1'b0;
    flags_restore = 1'b0;
    flags_restore_val = 3'b000;
    imm = '0;
    sp_low = '0;
    in_port = '0;
    fwd_data = '0;
    set_ops(MOV, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_hi", 32'(result_hi), 32'd0);
    chk("rst_flags", 32'(flags_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    sc(ADD,  16'h0001, 16'hFFFF, 4'd0, 1'b1, 16'h0000, 3'b101);
    sc(SUB,  16'h0005, 16'h0003, 4'd0, 1'b1, 16'hFFFE, 3'b110);
    sc(AND_, 16'h0F0F, 16'h00FF, 4'd0, 1'b1, 16'h000F, 3'b100);
    set_ops(CLRC, '0, '0, '0, 1'b1);
    fire_sc('0, 3'b000, 1'b0);
    set_ops(SETC, '0, '0, '0, 1'b1);
    fire_sc('0, 3'b100, 1'b0);
    set_ops(CLRC, '0, '0, '0, 1'b1);
    fire_sc('0, 3'b000, 1'b0);
    sc(SHL,  16'h0000, 16'h8001, 4'd1, 1'b1, 16'h0002, 3'b100);
    sc(SHR,  16'h0000, 16'h0004, 4'd1, 1'b1, 16'h0002, 3'b000);
    sc(SHL,  16'h0000, 16'h8000, 4'd0, 1'b1, 16'h8000, 3'b010);
    set_ops(SETC, '0, '0, '0, 1'b1);
    fire_sc('0, 3'b110, 1'b0);
    sc(SHR,  16'h0000, 16'h0003, 4'd0, 1'b1, 16'h0003, 3'b100);
    sc(INC,  16'h0000, 16'hFFFF, 4'd0, 1'b1, 16'h0000, 3'b101);
    sc(DEC,  16'h0000, 16'h0000, 4'd0, 1'b1, 16'hFFFF, 3'b110);
    sc(NOT_, 16'h0000, 16'h00FF, 4'd0, 1'b1, 16'hFF00, 3'b110);
    sc(OR_,  16'h0F00, 16'h00F0, 4'd0, 1'b0, 16'h0FF0, 3'b110);

    // forwarded A
    set_ops(MOV, '0, '0, '0, 1'b0);
    fwd_a_sel = 2'd2;
    fwd_data = {16'h0000, 16'h1234, 16'h0000};
    #1;
    chk("fwd_operand_a", 32'(operand_a), 32'h1234);
    fire_sc(16'h1234, 3'b110, 1'b1);

    // imm for A, shamt as B
    set_ops(ADD, '0, '0, 4'd3, 1'b1);
    a_sel = 2'b10;
    imm = 16'h0010;
    b_sel = 1'b1;
    fire_sc(16'h0013, 3'b000, 1'b1);

    // sp_low for A, forwarded slice 2 for B
    set_ops(SUB, '0, '0, '0, 1'b1);
    a_sel = 2'b11;
    sp_low = 16'h4001;
    fwd_b_sel = 2'd3;
    fwd_data = {16'h4000, 16'h0000, 16'h0000};
    #1;
    chk("sp_operand_a", 32'(operand_a), 32'h4001);
    fire_sc(16'hFFFF, 3'b110, 1'b1);

    sc(PASS, 16'h0000, 16'hABCD, 4'd0, 1'b0, 16'hABCD, 3'b110);

    run_mc(MUL,  16'h0100, 16'h0300, 1'b1, 1'b0,
           16'h0000, 16'h0003, 3'b101);
    run_mc(MUL,  16'hFFFF, 16'hFFFF, 1'b1, 1'b1,
           16'h0001, 16'hFFFE, 3'b100);
    run_mc(DIVU, 16'h0000, 16'd100, 1'b1, 1'b0,
           16'hFFFF, 16'd100, 3'b110);
    run_mc(DIVU, 16'd7, 16'd1000, 1'b1, 1'b0,
           16'h008E, 16'h0006, 3'b000);

    // flush mid-MUL
    set_ops(MUL, 16'h0003, 16'h0005, '0, 1'b1);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_flush", 32'(stall_out), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_stall", 32'(stall_out), 32'd0);
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_flags", 32'(flags_out), 32'd0);
    repeat (20) @(posedge clk);
    #1;

    // flush in IDLE drops a same-cycle instruction
    set_ops(ADD, 16'h0001, 16'hFFFF, '0, 1'b1);
    valid_in = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_drop_valid", 32'(valid_out), 32'd0);
    chk("flush_drop_flags", 32'(flags_out), 32'd0);
    @(posedge clk);
    #1;

    sc(ADD, 16'h0002, 16'h0003, 4'd0, 1'b1, 16'h0005, 3'b000);

    // restore beats a flag-writing SUB
    set_ops(SUB, 16'h0001, 16'h0001, '0, 1'b1);
    flags_restore = 1'b1;
    flags_restore_val = 3'b101;
    fire_sc(16'h0000, 3'b101, 1'b1);
    flags_restore = 1'b0;

    sc(ADD, 16'h0010, 16'h0020, 4'd0, 1'b0, 16'h0030, 3'b101);

    // async reset mid-DIVU
    set_ops(DIVU, 16'd3, 16'd50, '0, 1'b1);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", 32'(stall_out), 32'd0);
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_result_hi", 32'(result_hi), 32'd0);
    chk("arst_flags", 32'(flags_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
